// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR generator family.
//   lfsr_mode_e  - feedback form selector (FIBONACCI / GALOIS)
//   TAPS_Wn      - maximal-length feedback masks for common widths
//   DEFAULT_SEED - reset / substitute seed used when none is given
package lfsr_pkg;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  localparam int unsigned MIN_WIDTH = 3;
  localparam int unsigned MAX_WIDTH = 32;

  // Convert the integer GALOIS parameter into the mode enum.
  function automatic lfsr_mode_e mode_from_int(input int unsigned galois);
    mode_from_int = (galois != 0) ? lfsr_pkg::GALOIS : lfsr_pkg::FIBONACCI;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: purely combinational one-step successor of an LFSR state.
//   state      - current register value (WIDTH bits)
//   next_state - value after one step (WIDTH bits)
// Fibonacci: the parity of the tapped bits shifts in at bit 0.
// Galois:    the MSB rotates to bit 0 and is XORed into every bit i
//            whose lower neighbour (i-1) is tapped.
module lfsr_next #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = lfsr_pkg::TAPS_W8,
  parameter int unsigned      GALOIS = 0
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  import lfsr_pkg::*;

  localparam lfsr_mode_e MODE = mode_from_int(GALOIS);

  generate
    if (MODE == lfsr_pkg::GALOIS) begin : g_galois
      always_comb begin
        next_state    = '0;
        next_state[0] = state[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
          next_state[i] = state[i-1] ^ (TAPS[i-1] & state[WIDTH-1]);
        end
      end
    end else begin : g_fibonacci
      logic fb;
      always_comb begin
        fb         = ^(state & TAPS);
        next_state = {state[WIDTH-2:0], fb};
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised pseudo-random / PRBS source.
//   clk        - clock
//   srst       - synchronous active-high reset
//   en         - advance one step this cycle
//   load       - load seed_in this cycle (zero is replaced by SEED)
//   seed_in    - runtime seed
//   state_out  - current register state
//   bit_out    - serial output, MSB of state_out
//   wrap       - pulse: the step just taken returned to the active seed
//   period_len - step count of the last completed period
//   seed_err   - pulse: a zero seed was loaded and replaced by SEED
// Priority is srst > load > en. All outputs come straight from registers.
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = lfsr_pkg::TAPS_W8,
  parameter logic [WIDTH-1:0] SEED   = lfsr_pkg::DEFAULT_SEED[WIDTH-1:0],
  parameter int unsigned      GALOIS = 0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  import lfsr_pkg::*;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Elaboration guards: an untapped MSB makes the step non-invertible,
  // which would admit lock-up and break the period bookkeeping.
  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be within 3..32");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_gen: TAPS[WIDTH-1] must be set");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
    end
  endgenerate

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             seed_zero;

  lfsr_next #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .GALOIS (GALOIS)
  ) u_next (
    .state      (state_q),
    .next_state (step_val)
  );

  always_comb begin
    seed_zero = (seed_in == '0);
    load_val  = seed_zero ? SEED : seed_in;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= SEED;
      seed_reg   <= SEED;
      period_cnt <= '0;
      period_len <= '0;
      wrap       <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      seed_err <= 1'b0;
      if (load) begin
        state_q    <= load_val;
        seed_reg   <= load_val;
        period_cnt <= '0;
        seed_err   <= seed_zero;
      end else if (en) begin
        state_q <= step_val;
        // The period closes on the step that lands back on the active seed;
        // that step itself is counted, hence period_cnt + 1.
        if (step_val == seed_reg) begin
          wrap       <= 1'b1;
          period_len <= period_cnt + ONE;
          period_cnt <= '0;
        end else begin
          period_cnt <= period_cnt + ONE;
        end
      end
    end
  end

  assign state_out = state_q;
  assign bit_out   = state_q[WIDTH-1];

endmodule
